// File: rtl/a2d_pkg.sv
// Shared constants for the ADC128S-style SPI slave with pot inputs.
package a2d_pkg;
    localparam int FRAME_BITS = 16;
    localparam int DATA_W     = 12;

    typedef logic [2:0] chan_t;

    localparam chan_t CH_B1  = 3'd0;
    localparam chan_t CH_LP  = 3'd1;
    localparam chan_t CH_B3  = 3'd2;
    localparam chan_t CH_HP  = 3'd3;
    localparam chan_t CH_B2  = 3'd4;
    localparam chan_t CH_VOL = 3'd7;
endpackage

// File: rtl/spi_slave_edge_sync.sv
// Synchronizes SS_n/SCLK/MOSI into clk and detects SCLK and SS_n edges
// from the last two synchronized samples.
module spi_slave_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ss_n_i,
    input  logic sclk_i,
    input  logic mosi_i,
    output logic ss_n_s_o,
    output logic mosi_s_o,
    output logic sclk_rise_o,
    output logic sclk_fall_o,
    output logic ss_fall_o,
    output logic ss_rise_o
);
    logic [SYNC_STAGES-1:0] ss_sync_q;
    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic                   ss_prev_q;
    logic                   sclk_prev_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ss_sync_q   <= '0;
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            ss_prev_q   <= 1'b0;
            sclk_prev_q <= 1'b0;
        end else begin
            ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], ss_n_i};
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_i};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
            ss_prev_q   <= ss_sync_q[SYNC_STAGES-1];
            sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
        end
    end

    assign ss_n_s_o    = ss_sync_q[SYNC_STAGES-1];
    assign mosi_s_o    = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_rise_o =  sclk_sync_q[SYNC_STAGES-1] & ~sclk_prev_q;
    assign sclk_fall_o = ~sclk_sync_q[SYNC_STAGES-1] &  sclk_prev_q;
    assign ss_fall_o   = ~ss_sync_q[SYNC_STAGES-1] &  ss_prev_q;
    assign ss_rise_o   =  ss_sync_q[SYNC_STAGES-1] & ~ss_prev_q;
endmodule

// File: rtl/a2d_with_pots.sv
// SPI-slave model of an 8-channel 12-bit A2D; each frame returns the channel
// chosen by the previous complete frame and captures a new channel select.
module a2d_with_pots
    import a2d_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        SS_n,
    input  logic        SCLK,
    input  logic        MOSI,
    output logic        MISO,
    input  logic [11:0] LP,
    input  logic [11:0] B1,
    input  logic [11:0] B2,
    input  logic [11:0] B3,
    input  logic [11:0] HP,
    input  logic [11:0] VOL
);
    logic ss_n_s, mosi_s, sclk_rise, sclk_fall, ss_fall, ss_rise;

    spi_slave_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .ss_n_i     (SS_n),
        .sclk_i     (SCLK),
        .mosi_i     (MOSI),
        .ss_n_s_o   (ss_n_s),
        .mosi_s_o   (mosi_s),
        .sclk_rise_o(sclk_rise),
        .sclk_fall_o(sclk_fall),
        .ss_fall_o  (ss_fall),
        .ss_rise_o  (ss_rise)
    );

    logic [FRAME_BITS-1:0] tx_shft_q, tx_shft_d;
    // Only bits [13:11] of the received word are ever used, so the top two are not kept.
    logic [13:0]           rx_shft_q, rx_shft_d;
    logic [4:0]            bit_cnt_q, bit_cnt_d;
    chan_t                 chan_q, chan_d;
    logic [DATA_W-1:0]     pot_val;

    always_comb begin
        case (chan_q)
            CH_B1:   pot_val = B1;
            CH_LP:   pot_val = LP;
            CH_B3:   pot_val = B3;
            CH_HP:   pot_val = HP;
            CH_B2:   pot_val = B2;
            CH_VOL:  pot_val = VOL;
            default: pot_val = '0;
        endcase
    end

    // SS_n fall wins over any SCLK edge landing in the same sample.
    always_comb begin
        tx_shft_d = tx_shft_q;
        rx_shft_d = rx_shft_q;
        bit_cnt_d = bit_cnt_q;
        chan_d    = chan_q;
        if (ss_fall) begin
            tx_shft_d = {{(FRAME_BITS-DATA_W){1'b0}}, pot_val};
            bit_cnt_d = '0;
        end else if (!ss_n_s) begin
            if (sclk_fall)
                tx_shft_d = {tx_shft_q[FRAME_BITS-2:0], 1'b0};
            if (sclk_rise) begin
                rx_shft_d = {rx_shft_q[12:0], mosi_s};
                if (bit_cnt_q != 5'(FRAME_BITS + 1))
                    bit_cnt_d = bit_cnt_q + 5'd1;
            end
        end else if (ss_rise && bit_cnt_q == 5'(FRAME_BITS)) begin
            chan_d = rx_shft_q[13:11];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_shft_q <= '0;
            rx_shft_q <= '0;
            bit_cnt_q <= '0;
            chan_q    <= 3'd0;
        end else begin
            tx_shft_q <= tx_shft_d;
            rx_shft_q <= rx_shft_d;
            bit_cnt_q <= bit_cnt_d;
            chan_q    <= chan_d;
        end
    end

    assign MISO = SS_n ? 1'bz : tx_shft_q[FRAME_BITS-1];
endmodule

// File: tb/tb_a2d_with_pots.sv
// Self-checking bench for a2d_with_pots: directed table, corner sequences and
// randomized frames against a channel-pointer reference model.
module tb_a2d_with_pots;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        SS_n = 1'b1;
    logic        SCLK = 1'b0;
    logic        MOSI = 1'b0;
    logic [11:0] LP = '0, B1 = '0, B2 = '0, B3 = '0, HP = '0, VOL = '0;
    wire         miso_w;

    // Pull-up makes an undriven (high-Z) MISO observable as 1.
    pullup (miso_w);

    a2d_with_pots #(.SYNC_STAGES(2)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .SS_n (SS_n),
        .SCLK (SCLK),
        .MOSI (MOSI),
        .MISO (miso_w),
        .LP   (LP),
        .B1   (B1),
        .B2   (B2),
        .B3   (B3),
        .HP   (HP),
        .VOL  (VOL)
    );

    always #5 clk = ~clk;

    int       n_checks = 0;
    int       n_errors = 0;
    int       ptr_m = 0;

    typedef struct {
        int          ch;
        logic [15:0] exp;
    } vec_t;
    vec_t vecs[8];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [11:0] pot_of(input int ch);
        case (ch)
            0: return B1;
            1: return LP;
            2: return B3;
            3: return HP;
            4: return B2;
            7: return VOL;
            default: return 12'h000;
        endcase
    endfunction

    task automatic do_reset();
        @(negedge clk) rst_n = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        ptr_m = 0;
    endtask

    // One master frame; frames of 16+ bits are checked against the model.
    task automatic frame(input logic [15:0] cmd, input int nbits, input int chg_bit,
                         input logic [11:0] chg_hp, output logic [15:0] resp);
        logic [15:0] exp;
        exp  = {4'h0, pot_of(ptr_m)};
        resp = '0;
        @(negedge clk) SS_n = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            if (i == chg_bit) HP = chg_hp;
            MOSI = (i < 16) ? cmd[15-i] : 1'b0;
            repeat (4) @(negedge clk);
            if (i < 16) resp[15-i] = miso_w;
            SCLK = 1'b1;
            repeat (4) @(negedge clk);
            SCLK = 1'b0;
        end
        repeat (4) @(negedge clk);
        SS_n = 1'b1;
        repeat (8) @(negedge clk);
        check("idle_hiz", {15'h0, miso_w}, 16'h0001);
        if (nbits >= 16) check("model_resp", resp, exp);
        if (nbits == 16) ptr_m = int'(cmd[13:11]);
    endtask

    logic [15:0] r;
    logic [15:0] cmd_r;
    int          nb;

    initial begin
        vecs[0] = '{0, 16'h0111};
        vecs[1] = '{1, 16'h0222};
        vecs[2] = '{2, 16'h0333};
        vecs[3] = '{3, 16'h0444};
        vecs[4] = '{4, 16'h0555};
        vecs[5] = '{5, 16'h0000};
        vecs[6] = '{6, 16'h0000};
        vecs[7] = '{7, 16'h0FFF};

        do_reset();
        check("reset_idle_hiz", {15'h0, miso_w}, 16'h0001);

        B1 = 12'hA5C;
        frame(16'h0000, 16, -1, 12'h0, r);
        check("first_frame_b1", r, 16'h0A5C);
        frame(16'h0000, 16, -1, 12'h0, r);
        check("ptr_stays_0", r, 16'h0A5C);

        frame(16'h0800, 16, -1, 12'h0, r);
        LP = 12'h123;
        frame(16'h0000, 16, -1, 12'h0, r);
        check("ch1_lp", r, 16'h0123);

        B1 = 12'h111; LP = 12'h222; B3 = 12'h333; HP = 12'h444; B2 = 12'h555; VOL = 12'hFFF;
        for (int i = 0; i < 8; i++) begin
            frame(16'(vecs[i].ch << 11), 16, -1, 12'h0, r);
            frame(16'h0000, 16, -1, 12'h0, r);
            check($sformatf("table_ch%0d", vecs[i].ch), r, vecs[i].exp);
        end

        // Truncated command must not move the pointer off channel 3.
        frame(16'h1800, 16, -1, 12'h0, r);
        frame(16'h3800, 10, -1, 12'h0, r);
        frame(16'h1800, 16, -1, 12'h0, r);
        check("short_frame_ignored", r, 16'h0444);
        frame(16'h3800, 17, -1, 12'h0, r);
        frame(16'h1800, 16, -1, 12'h0, r);
        check("long_frame_ignored", r, 16'h0444);

        HP = 12'h100;
        frame(16'h1800, 16, 5, 12'h200, r);
        check("hp_frozen", r, 16'h0100);
        frame(16'h1800, 16, -1, 12'h0, r);
        check("hp_fresh", r, 16'h0200);

        // Reset in the middle of a frame after selecting channel 7.
        frame(16'h3800, 16, -1, 12'h0, r);
        @(negedge clk) SS_n = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            SCLK = 1'b1; repeat (4) @(negedge clk);
            SCLK = 1'b0; repeat (4) @(negedge clk);
        end
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_miso_low", {15'h0, miso_w}, 16'h0000);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        SS_n = 1'b1;
        ptr_m = 0;
        repeat (8) @(negedge clk);
        check("rst_idle_hiz", {15'h0, miso_w}, 16'h0001);
        frame(16'h0000, 16, -1, 12'h0, r);
        check("rst_returns_b1", r, 16'h0111);

        for (int k = 0; k < 40; k++) begin
            B1 = 12'($urandom); LP = 12'($urandom); B2 = 12'($urandom);
            B3 = 12'($urandom); HP = 12'($urandom); VOL = 12'($urandom);
            cmd_r = 16'($urandom);
            case ($urandom_range(0, 5))
                0:       nb = 10;
                1:       nb = 17;
                default: nb = 16;
            endcase
            frame(cmd_r, nb, -1, 12'h0, r);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL timeout: simulation did not complete, expected finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/a2d_with_pots.md
Name: a2d_with_pots

Overview:
- Synthesizable SPI-slave model of an 8-channel, 12-bit A2D converter (ADC128S-style) with six slide-pot values applied as parallel inputs.
- Sits on the equalizer's ADC SPI bus and answers the SPI master that reads the band-gain and volume pots.
- Each 16-bit transaction returns the conversion for the channel selected by the previous transaction and captures a new channel select.

Parameters:
- SYNC_STAGES, 2, number of flops in the synchronizers on SS_n, SCLK and MOSI (minimum 2).

Ports:
- clk  input  1  system clock; all logic is on its rising edge.
- rst_n  input  1  synchronous active-low reset.
- SS_n  input  1  SPI slave select, active low; frames one 16-bit transaction.
- SCLK  input  1  SPI serial clock, mode 0; period ≥ 4 clk periods.
- MOSI  input  1  SPI command data, MSB first.
- MISO  output  1  SPI response data, MSB first; high-Z while SS_n is high.
- LP  input  12  low-pass pot value, channel 1.
- B1  input  12  band-1 pot value, channel 0.
- B2  input  12  band-2 pot value, channel 4.
- B3  input  12  band-3 pot value, channel 2.
- HP  input  12  high-pass pot value, channel 3.
- VOL  input  12  volume pot value, channel 7.

Behaviour:
- Clocking and reset: one clock, synchronous active-low reset on rst_n. Reset clears:
  - synchronizers, edge-detect flops, rx/tx shift registers and bit counter to 0
  - channel pointer to 3'd0
- Reset mid-transaction aborts the transaction. MISO then follows SS_n: high-Z if high, tx_shft[15]=0 if low.
- Input sampling: SS_n, SCLK and MOSI pass through SYNC_STAGES flops. SCLK rise/fall and SS_n fall/rise are detected from the last two synchronized samples.
- Value mux, channel to value:
  - 0 → B1, 1 → LP, 2 → B3, 3 → HP, 4 → B2, 7 → VOL
  - 5 and 6 → 12'h000
- On SS_n fall:
  - tx_shft[15:0] loads {4'h0, mux(channel pointer)}.
  - Bit counter clears.
  - Pot values are frozen for the transaction; later input changes do not affect it.
- MISO = tx_shft[15] while raw SS_n is low, otherwise 1'bz. The first bit is valid before the first SCLK rise.
- On each SCLK fall with SS_n low: tx_shft shifts left one bit, 0 fills the LSB.
- On each SCLK rise with SS_n low:
  - rx_shft shifts left, MOSI enters at bit 0.
  - Bit counter increments, saturating at 17.
- On SS_n rise: if bit counter == 16, channel pointer loads rx_shft[13:11]. Otherwise the pointer is unchanged (short or long frame ignored).
- The pointer persists across transactions. Repeating a command re-reads the same channel with fresh data at the next SS_n fall.
- The first transaction after reset returns the channel-0 (B1) value.
- Edges seen while SS_n is high are ignored.
- Simultaneous SS_n fall and SCLK edge in the same synchronized sample: the SS_n load takes priority and the SCLK edge is ignored.

Decomposition:
- Shared package a2d_pkg holds:
  - channel localparams: CH_B1=0, CH_LP=1, CH_B3=2, CH_HP=3, CH_B2=4, CH_VOL=7
  - FRAME_BITS=16, DATA_W=12
- One sub-module, spi_slave_edge_sync: synchronizers plus rise/fall detect for SCLK and SS_n.
- Channel mux and shift registers stay in the top.

Test Plan:
- Reset, then one transaction with MOSI=16'h0000 and B1=12'hA5C → MISO returns 16'h0A5C; pointer stays 0.
- Command 16'h0800 (ch1), then second frame with LP=12'h123 → second frame returns 16'h0123.
- For each channel 0,1,2,3,4,7 with distinct pot values (e.g. B1=0x111, LP=0x222, B3=0x333, HP=0x444, B2=0x555, VOL=0xFFF): command ch N, next frame → {4'h0, value}. Channels 5 and 6 → 16'h0000.
- Send command ch7 truncated to 10 SCLKs, then full frame → returns the previous channel's value; pointer is not 7.
- Select ch3, change HP from 0x100 to 0x200 mid-frame → that frame returns 0x0100 and the next returns 0x0200.
- Assert rst_n low mid-frame after selecting ch7 → next complete frame returns the B1 value; MISO is high-Z whenever SS_n is high.
